// File: rtl/karat_mac_seq_if.sv
// rtl/karat_mac_seq_if.sv - operand/result handshake bundle for karat_mac_seq
interface karat_mac_seq_if #(
  parameter int wI = 128,
  parameter int wA = 272
);
  logic          i_valid;
  logic          o_ready;
  logic [wI-1:0] iX;
  logic [wI-1:0] iY;
  logic          i_accum;
  logic          o_valid;
  logic          i_ready;
  logic [wA-1:0] oO;
  logic          o_ovf;

  modport master (
    output i_valid, iX, iY, i_accum, i_ready,
    input  o_ready, o_valid, oO, o_ovf
  );

  modport slave (
    input  i_valid, iX, iY, i_accum, i_ready,
    output o_ready, o_valid, oO, o_ovf
  );
endinterface

// File: rtl/karat_mac_seq.sv
// rtl/karat_mac_seq.sv - one-level Karatsuba MAC over a shared pipelined half-width multiplier
module karat_mac_seq #(
  parameter int wI    = 128,
  parameter int wA    = 272,
  parameter int nPIPE = 2
) (
  input  logic              clk,
  input  logic              rst,
  karat_mac_seq_if.slave    bus
);
  localparam int h  = wI / 2;
  localparam int wM = h + 1;       // half-width operand plus carry of xl+xh
  localparam int wP = 2 * h + 2;   // product of two wM-bit operands

  if ((wI % 2) != 0 || wI < 4) begin : g_bad_wi
    $error("karat_mac_seq: wI must be even and >= 4");
  end
  if (wA < 2 * wI) begin : g_bad_wa
    $error("karat_mac_seq: wA must be >= 2*wI");
  end
  if (nPIPE < 1) begin : g_bad_pipe
    $error("karat_mac_seq: nPIPE must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, ISS0, ISS1, ISS2, WAIT, COMB, DONE} state_t;

  localparam logic [1:0] TAG_Z0 = 2'd0;
  localparam logic [1:0] TAG_Z2 = 2'd1;
  localparam logic [1:0] TAG_Z1 = 2'd2;

  state_t        state, state_nx;
  logic [wI-1:0] x_r, y_r;
  logic          acc_sel;
  logic [wA-1:0] acc;
  logic          ovf;
  logic [wP-1:0] z0, z2, z1;

  logic [wP-1:0] pipe_d [nPIPE];
  logic [1:0]    pipe_t [nPIPE];
  logic [nPIPE-1:0] pipe_v;

  logic          issue;
  logic [1:0]    issue_tag;
  logic [wM-1:0] mul_a, mul_b;
  logic          accept;

  logic [wP-1:0] mid;
  logic [wA-1:0] prod;
  logic [wA-1:0] base;
  logic [wA:0]   sum;

  assign accept      = (state == IDLE) && bus.i_valid;
  assign bus.o_ready = (state == IDLE) && !rst;
  assign bus.o_valid = (state == DONE);
  assign bus.oO      = acc;
  assign bus.o_ovf   = ovf;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // sequencing and multiplier operand selection for the three partial products
  always_comb begin
    state_nx  = state;
    issue     = 1'b0;
    issue_tag = TAG_Z0;
    mul_a     = '0;
    mul_b     = '0;
    case (state)
      IDLE: if (bus.i_valid) state_nx = ISS0;
      ISS0: begin
        issue     = 1'b1;
        issue_tag = TAG_Z0;
        mul_a     = {1'b0, x_r[h-1:0]};
        mul_b     = {1'b0, y_r[h-1:0]};
        state_nx  = ISS1;
      end
      ISS1: begin
        issue     = 1'b1;
        issue_tag = TAG_Z2;
        mul_a     = {1'b0, x_r[wI-1:h]};
        mul_b     = {1'b0, y_r[wI-1:h]};
        state_nx  = ISS2;
      end
      ISS2: begin
        issue     = 1'b1;
        issue_tag = TAG_Z1;
        mul_a     = {1'b0, x_r[h-1:0]} + {1'b0, x_r[wI-1:h]};
        mul_b     = {1'b0, y_r[h-1:0]} + {1'b0, y_r[wI-1:h]};
        state_nx  = WAIT;
      end
      WAIT: if (pipe_v[nPIPE-1] && pipe_t[nPIPE-1] == TAG_Z1) state_nx = COMB;
      COMB: state_nx = DONE;
      DONE: if (bus.i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // operand capture on the input handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r     <= '0;
      y_r     <= '0;
      acc_sel <= 1'b0;
    end else if (accept) begin
      x_r     <= bus.iX;
      y_r     <= bus.iY;
      acc_sel <= bus.i_accum;
    end
  end

  // shared multiplier: product registered at issue, then shifted through nPIPE-1 more stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < nPIPE; i++) begin
        pipe_d[i] <= '0;
        pipe_t[i] <= TAG_Z0;
      end
    end else begin
      pipe_v[0] <= issue;
      pipe_d[0] <= mul_a * mul_b;
      pipe_t[0] <= issue_tag;
      for (int i = 1; i < nPIPE; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
        pipe_t[i] <= pipe_t[i-1];
      end
    end
  end

  // steer each product leaving the pipe into its partial-product register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z0 <= '0;
      z2 <= '0;
      z1 <= '0;
    end else if (pipe_v[nPIPE-1]) begin
      case (pipe_t[nPIPE-1])
        TAG_Z0:  z0 <= pipe_d[nPIPE-1];
        TAG_Z2:  z2 <= pipe_d[nPIPE-1];
        default: z1 <= pipe_d[nPIPE-1];
      endcase
    end
  end

  // recombine partial products and add onto the (optionally cleared) accumulator
  always_comb begin
    mid  = z1 - z0 - z2;  // xl*yh + xh*yl, never negative
    prod = (wA'(z2) << wI) + (wA'(mid) << h) + wA'(z0);
    base = acc_sel ? acc : {wA{1'b0}};
    sum  = {1'b0, base} + {1'b0, prod};
  end

  // accumulator and sticky overflow update in COMB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (state == COMB) begin
      acc <= sum[wA-1:0];
      ovf <= acc_sel ? (ovf | sum[wA]) : sum[wA];
    end
  end
endmodule
